// File: rtl/uart_tx_frame_ctrl.sv
// ============================================================================
// Module   : uart_tx_frame_ctrl
// Purpose  : UART Tx framing - start, WIDTH data bits LSB-first, optional
//            parity bit, one stop bit; one bit per baud clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             Parity_Bit,
  output logic             TX_OUT,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             parity_q;
  logic             par_en_q;
  logic             tx_q;
  logic             busy_q;
  logic             accept_d;

  assign accept_d = DATA_VALID && ((state_q == S_IDLE) || (state_q == S_STOP));

  // Outputs are loaded with the value for the state being entered, so the
  // line reflects the new state from the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_STOP: begin
          if (accept_d) begin
            shift_q  <= P_DATA;
            par_en_q <= PAR_EN;
            state_q  <= S_START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        S_START: begin
          parity_q <= Parity_Bit;
          cnt_q    <= '0;
          state_q  <= S_DATA;
          tx_q     <= shift_q[0];
          shift_q  <= shift_q >> 1;
          busy_q   <= 1'b1;
        end
        S_DATA: begin
          if (cnt_q == c_LAST_BIT) begin
            if (par_en_q) begin
              state_q <= S_PARITY;
              tx_q    <= parity_q;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            busy_q  <= 1'b1;
          end
        end
        S_PARITY: begin
          state_q <= S_STOP;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
// ============================================================================
// Module   : tb_uart_tx_frame_ctrl
// Purpose  : Self-checking bench; expected line is a queue of frame bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_frame_ctrl;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] P_DATA = '0;
  logic             DATA_VALID = 1'b0;
  logic             PAR_EN = 1'b0;
  logic             Parity_Bit = 1'b0;
  logic             TX_OUT;
  logic             BUSY;

  int        n_cmp = 0;
  int        n_err = 0;
  bit        exp_q[$];
  logic [15:0] line_hist = '0;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.WIDTH(WIDTH)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .Parity_Bit (Parity_Bit),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One baud cycle: drive inputs, advance the model, then check outputs.
  task automatic step(input logic rst, input logic dv, input logic [WIDTH-1:0] d,
                      input logic pen, input logic pb);
    logic acc;
    RST        = rst;
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pen;
    acc = !rst && dv && (exp_q.size() <= 1);
    if (acc) Parity_Bit = pb;
    @(posedge CLK);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(d[i]);
        if (pen) exp_q.push_back(pb);
        exp_q.push_back(1'b1);
      end
    end
    @(negedge CLK);
    line_hist = {line_hist[14:0], TX_OUT};
    check_val("tx",   {31'd0, TX_OUT}, (exp_q.size() > 0) ? {31'd0, exp_q[0]} : 32'd1);
    check_val("busy", {31'd0, BUSY},   (exp_q.size() > 1) ? 32'd1 : 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge CLK);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(5);

    // 0xA5 with even parity (parity bit 0)
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    idle(10);
    check_val("a5_even_seq", {21'd0, line_hist[10:0]}, {21'd0, 11'b01010010101});
    idle(2);

    // 0xA5 with odd parity (parity bit 1)
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    idle(10);
    check_val("a5_odd_seq", {21'd0, line_hist[10:0]}, {21'd0, 11'b01010010111});
    idle(2);

    // 0x01 without parity
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    idle(9);
    check_val("01_nopar_seq", {22'd0, line_hist[9:0]}, {22'd0, 10'b0100000001});
    idle(2);

    // Back-to-back: second word offered while the first frame's stop bit is out
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    idle(9);
    step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    check_val("b2b_stop_start", {30'd0, line_hist[1:0]}, 32'b10);
    idle(10);
    check_val("ff_even_seq", {21'd0, line_hist[10:0]}, {21'd0, 11'b01111111101});
    idle(2);

    // Word offered mid-DATA must be dropped
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    idle(6);
    check_val("a5_drop_seq", {21'd0, line_hist[10:0]}, {21'd0, 11'b01010010101});
    idle(5);

    // Reset at data bit 3 aborts the frame
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
    idle(12);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35),
           WIDTH'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
